// File: rtl/mac_acc_pkg.sv
// Shared definitions for the dual-lane MAC vector accumulator:
// default widths, control state encoding and the accumulator type.
package mac_acc_pkg;

    localparam int DIN_W_DEF = 17;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/mac_acc_if.sv
// Stream bundle between the doubleMAC stage, the accumulator and its
// consumer. The slave view belongs to the accumulator; the master view
// belongs to whatever drives beats and takes results.
interface mac_acc_if
    import mac_acc_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) ();

    logic [LEN_W-1:0]        len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DIN_W-1:0] din0;
    logic signed [DIN_W-1:0] din1;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc0;
    logic signed [ACC_W-1:0] acc1;
    logic [1:0]              ovf;
    logic                    busy;

    modport slave (
        input  len, in_valid, din0, din1, out_ready,
        output in_ready, out_valid, acc0, acc1, ovf, busy
    );

    modport master (
        output len, in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, acc0, acc1, ovf, busy
    );

endinterface

// File: rtl/mac_acc_lane.sv
// One accumulator lane: sign-extends the MAC result and adds it to the
// running sum. The first beat of a vector adds onto zero, so the running
// sum never needs clearing. sum_nxt/ovf_nxt include the current beat so the
// controller can capture a finished vector without an extra cycle.
// Optional macro MAC_ACC_SAT_EN: saturating adds with a sticky per-vector
// overflow flag; otherwise adds wrap and ovf_nxt is constant 0.
module mac_acc_lane #(
    parameter int DIN_W = 17,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    beat,
    input  logic                    first,
    input  logic signed [DIN_W-1:0] din,
    output logic signed [ACC_W-1:0] sum_nxt,
    output logic                    ovf_nxt
);

    logic signed [ACC_W-1:0] din_ext_p0;
    logic signed [ACC_W-1:0] base_p0;
    logic signed [ACC_W-1:0] acc_p1;

    assign din_ext_p0 = ACC_W'(din);
    assign base_p0    = first ? '0 : acc_p1;

`ifdef MAC_ACC_SAT_EN
    logic signed [ACC_W:0] sum_wide_p0;
    logic                  ovf_p1;

    function automatic logic signed [ACC_W:0] add_wide(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return (ACC_W+1)'(a) + (ACC_W+1)'(b);
    endfunction

    function automatic logic wide_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    assign sum_wide_p0 = add_wide(base_p0, din_ext_p0);
    assign sum_nxt     = sat(sum_wide_p0);
    assign ovf_nxt     = (first ? 1'b0 : ovf_p1) | wide_ovf(sum_wide_p0);

    // Sticky overflow for the vector in progress; restarted by the first beat.
    always_ff @(posedge clk) begin
        if (beat)
            ovf_p1 <= ovf_nxt;
    end
`else
    assign sum_nxt = base_p0 + din_ext_p0;
    assign ovf_nxt = 1'b0;
`endif

    // --- stage p0 -> p1: running sum captured on every accepted beat ---
    always_ff @(posedge clk) begin
        if (beat)
            acc_p1 <= sum_nxt;
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dual-lane, vector-length-programmable accumulator behind the doubleMAC
// stage. Sums din0/din1 over len beats (len of 0 treated as 1) and presents
// both sums on a valid/ready port. The output register acts as a second
// buffer, so the next vector accumulates while the previous result waits;
// only a vector's final beat is stalled when that buffer is still occupied.
// Optional macro MAC_ACC_SAT_EN: saturating lanes with per-lane ovf flags.
module mac_accumulator
    import mac_acc_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input logic     clk,
    input logic     rst,
    mac_acc_if.slave bus
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t                  state_p1;
    state_t                  state_nxt;
    logic [LEN_W-1:0]        cnt_p1;
    logic [LEN_W-1:0]        len_p1;
    logic [LEN_W-1:0]        len_eff;
    logic                    first;
    logic                    final_beat;
    logic                    in_ready;
    logic                    beat;
    logic                    done;

    logic signed [ACC_W-1:0] sum0_nxt;
    logic signed [ACC_W-1:0] sum1_nxt;
    logic                    ovf0_nxt;
    logic                    ovf1_nxt;

    logic                    out_valid_p1;
    logic signed [ACC_W-1:0] acc0_p1;
    logic signed [ACC_W-1:0] acc1_p1;
    logic [1:0]              ovf_p1;

    assign len_eff    = (bus.len == '0) ? LEN_ONE : bus.len;
    assign first      = (state_p1 == IDLE);
    assign final_beat = (first && (len_eff == LEN_ONE))
                     || ((state_p1 == ACCUM) && (cnt_p1 == len_p1 - LEN_ONE));
    assign in_ready   = !(final_beat && out_valid_p1 && !bus.out_ready);
    assign beat       = bus.in_valid && in_ready;
    assign done       = beat && final_beat;

    mac_acc_lane #(.DIN_W(DIN_W), .ACC_W(ACC_W)) u_lane0 (
        .clk     (clk),
        .beat    (beat),
        .first   (first),
        .din     (bus.din0),
        .sum_nxt (sum0_nxt),
        .ovf_nxt (ovf0_nxt)
    );

    mac_acc_lane #(.DIN_W(DIN_W), .ACC_W(ACC_W)) u_lane1 (
        .clk     (clk),
        .beat    (beat),
        .first   (first),
        .din     (bus.din1),
        .sum_nxt (sum1_nxt),
        .ovf_nxt (ovf1_nxt)
    );

    // Next-state: leave IDLE on a non-final first beat, return on the final beat.
    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            IDLE:    if (beat && !final_beat) state_nxt = ACCUM;
            ACCUM:   if (beat && final_beat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_p1 <= IDLE;
        else
            state_p1 <= state_nxt;
    end

    // Beat counter; the vector length is latched on the first beat so later
    // changes to len cannot disturb a vector in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
            len_p1 <= '0;
        end else if (beat) begin
            if (first) begin
                cnt_p1 <= LEN_ONE;
                len_p1 <= len_eff;
            end else begin
                cnt_p1 <= cnt_p1 + LEN_ONE;
            end
        end
    end

    // --- stage p1: result buffer, reloaded on completion even while draining ---
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_p1 <= 1'b0;
            acc0_p1      <= '0;
            acc1_p1      <= '0;
            ovf_p1       <= 2'b00;
        end else if (done) begin
            out_valid_p1 <= 1'b1;
            acc0_p1      <= sum0_nxt;
            acc1_p1      <= sum1_nxt;
            ovf_p1       <= {ovf1_nxt, ovf0_nxt};
        end else if (bus.out_ready) begin
            out_valid_p1 <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_p1;
    assign bus.acc0      = acc0_p1;
    assign bus.acc1      = acc1_p1;
    assign bus.ovf       = ovf_p1;
    assign bus.busy      = (state_p1 == ACCUM);

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios followed by random traffic,
// all checked against a vector-level reference model (per-vector sums kept
// as integers, one-deep result buffer kept as a queue).
module tb_mac_accumulator;
    import mac_acc_pkg::*;

    localparam int DIN_W = DIN_W_DEF;
    localparam int ACC_W = ACC_W_DEF;
    localparam int LEN_W = LEN_W_DEF;
    localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_acc_if #(.DIN_W(DIN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    mac_accumulator #(.DIN_W(DIN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic last_ready;

    typedef struct {
        longint     a0;
        longint     a1;
        logic [1:0] ov;
    } res_t;

    res_t   slot[$];
    bit     in_vec;
    int     beats;
    int     vlen;
    longint m0, m1;
    bit     mo0, mo1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapv(input longint x);
        logic [ACC_W-1:0] t;
        t = x[ACC_W-1:0];
        return longint'($signed(t));
    endfunction

    task automatic lane_add(inout longint s, inout bit ov, input longint d);
`ifdef MAC_ACC_SAT_EN
        s = s + d;
        if (s > ACC_MAX) begin s = ACC_MAX; ov = 1'b1; end
        else if (s < ACC_MIN) begin s = ACC_MIN; ov = 1'b1; end
`else
        s = wrapv(s + d);
`endif
    endtask

    task automatic model_reset();
        in_vec = 1'b0;
        beats  = 0;
        vlen   = 0;
        slot.delete();
    endtask

    task automatic model_cycle();
        int L;
        bit fin, exp_rdy, acc;
        check("out_valid", bus.out_valid, slot.size() != 0);
        if (slot.size() != 0) begin
            check("acc0", bus.acc0, slot[0].a0);
            check("acc1", bus.acc1, slot[0].a1);
            check("ovf", bus.ovf, slot[0].ov);
        end
        check("busy", bus.busy, in_vec);
        L = in_vec ? vlen : ((bus.len == '0) ? 1 : int'(bus.len));
        fin = (beats + 1 == L);
        exp_rdy = !(fin && slot.size() != 0 && !bus.out_ready);
        check("in_ready", bus.in_ready, exp_rdy);
        acc = bus.in_valid && exp_rdy;
        if (slot.size() != 0 && bus.out_ready)
            void'(slot.pop_front());
        if (acc) begin
            if (!in_vec) begin
                in_vec = 1'b1; vlen = L; beats = 0;
                m0 = 0; m1 = 0; mo0 = 1'b0; mo1 = 1'b0;
            end
            lane_add(m0, mo0, longint'(bus.din0));
            lane_add(m1, mo1, longint'(bus.din1));
            beats++;
            if (beats == vlen) begin
                slot.push_back('{a0: m0, a1: m1, ov: {mo1, mo0}});
                in_vec = 1'b0;
                beats  = 0;
            end
        end
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, returns at posedge+1.
    task automatic step(input bit v, input int l, input longint d0, input longint d1,
                        input bit ordy);
        bus.in_valid  = v;
        bus.len       = LEN_W'(l);
        bus.din0      = DIN_W'(d0);
        bus.din1      = DIN_W'(d1);
        bus.out_ready = ordy;
        @(negedge clk);
        last_ready = bus.in_ready;
        if (rst) model_reset();
        else     model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint exp_big;
        logic [1:0] exp_big_ovf;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.len = '0; bus.din0 = '0; bus.din1 = '0; bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_acc0", bus.acc0, 0);
        check("rst_acc1", bus.acc1, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_busy", bus.busy, 0);

        // Basic sums, len=4
        for (int i = 1; i <= 4; i++) begin
            step(1, 4, i, -i, 1);
            if (i == 3) begin
                check("basic_mid_valid", bus.out_valid, 0);
                check("basic_mid_busy", bus.busy, 1);
            end
        end
        check("basic_valid", bus.out_valid, 1);
        check("basic_acc0", bus.acc0, 10);
        check("basic_acc1", bus.acc1, -10);
        check("basic_ovf", bus.ovf, 0);
        step(0, 4, 0, 0, 1);

        // Back-to-back len=1
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 5 + i, 0, 1);
            check("b2b_ready", last_ready, 1);
            check("b2b_valid", bus.out_valid, 1);
            check("b2b_acc0", bus.acc0, 5 + i);
        end
        step(0, 1, 0, 0, 1);

        // Backpressure, len=2
        step(1, 2, 11, 1, 0);
        step(1, 2, 12, 2, 0);
        check("bp_first_valid", bus.out_valid, 1);
        check("bp_first_acc0", bus.acc0, 23);
        step(1, 2, 100, 10, 0);
        check("bp_nonfinal_ready", last_ready, 1);
        step(1, 2, 200, 20, 0);
        check("bp_final_stalled", last_ready, 0);
        step(1, 2, 200, 20, 0);
        check("bp_still_stalled", last_ready, 0);
        check("bp_held_acc0", bus.acc0, 23);
        check("bp_held_acc1", bus.acc1, 3);
        step(1, 2, 200, 20, 1);
        check("bp_release_ready", last_ready, 1);
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_acc0", bus.acc0, 300);
        check("bp_second_acc1", bus.acc1, 30);
        step(0, 2, 0, 0, 1);
        check("bp_drained", bus.out_valid, 0);

        // Long vector: wrap or saturate
`ifdef MAC_ACC_SAT_EN
        exp_big = 8388607;
        exp_big_ovf = 2'b01;
`else
        exp_big = -65791;
        exp_big_ovf = 2'b00;
`endif
        for (int i = 0; i < 255; i++) step(1, 255, 65535, 0, 1);
        check("big_valid", bus.out_valid, 1);
        check("big_acc0", bus.acc0, exp_big);
        check("big_ovf", bus.ovf, exp_big_ovf);
        step(1, 1, 3, 0, 1);
        check("after_big_acc0", bus.acc0, 3);
        check("after_big_ovf", bus.ovf, 0);

        // len=0 behaves as len=1
        step(1, 0, 9, -9, 1);
        check("len0_valid", bus.out_valid, 1);
        check("len0_acc0", bus.acc0, 9);
        check("len0_acc1", bus.acc1, -9);
        step(0, 1, 0, 0, 1);

        // Reset mid-vector with a pending result
        step(1, 1, 42, 0, 0);
        step(1, 4, 1, 0, 0);
        step(1, 4, 1, 0, 0);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        step(0, 4, 0, 0, 0);
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) step(1, 4, 1, 0, 1);
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_acc0", bus.acc0, 4);
        step(0, 4, 0, 0, 1);

        // Random traffic, short vectors
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 5),
                 longint'($urandom_range(0, 131071)) - 65536,
                 longint'($urandom_range(0, 131071)) - 65536,
                 $urandom_range(0, 99) < 60);
        end

        // Random traffic, long vectors with extreme values
        for (int i = 0; i < 2000; i++) begin
            longint d0, d1;
            d0 = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 131071)) - 65536
                                              : (($urandom_range(0, 1) == 1) ? 65535 : -65536);
            d1 = ($urandom_range(0, 1) == 1) ? 65535 : longint'($urandom_range(0, 131071)) - 65536;
            step($urandom_range(0, 99) < 85, $urandom_range(100, 255), d0, d1,
                 $urandom_range(0, 99) < 70);
        end

        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        check("final_drained", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
